// File: rtl/circ_buf_pkg.sv
// Shared types and modular pointer arithmetic for the circular tap buffer.
// Wrap helpers take the buffer depth as an argument so DEPTH need not be a power of two.
package circ_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD    = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Operands are assumed already reduced modulo depth, so one subtract suffices.
   function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] depth);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, depth}) sum = sum - {1'b0, depth};
      return sum[31:0];
   endfunction

   function automatic logic [31:0] wrap_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] depth);
      if (a >= b) return a - b;
      return a + depth - b;
   endfunction

endpackage

// File: rtl/circ_buf_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no reset,
// written so that synthesis maps it onto block RAM.
module circ_buf_ram #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 800,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/circ_tap_buffer.sv
// Circular sample buffer returning N_TAPS delayed taps per sweep over a single read port.
// Define CIRC_BUF_NEWEST_REL_EN to measure tap offsets back from the newest sample instead of the oldest.
module circ_tap_buffer
   import circ_buf_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 800,
   parameter int N_TAPS = 4,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int TAP_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic [DATA_W-1:0]        w_val,
   input  logic                     start,
   input  logic [N_TAPS*ADDR_W-1:0] tap_offset,
   output logic                     s_ready,
   output logic                     busy,
   output logic                     r_valid,
   output logic [TAP_W-1:0]         r_tap,
   output logic [DATA_W-1:0]        r_data,
   output logic                     r_oob,
   output logic                     done,
   output logic [ADDR_W-1:0]        w_addr,
   output logic [ADDR_W-1:0]        oldest_addr,
   output logic [CNT_W-1:0]         fill,
   output logic                     full,
   output logic                     ovf
);

   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

   state_t              state;
   logic [TAP_W-1:0]    tap_cnt;
   logic                skid_vld;
   logic [DATA_W-1:0]   skid_val;
   logic [ADDR_W-1:0]   snap_base;
   logic [CNT_W-1:0]    snap_fill;
   logic [ADDR_W-1:0]   snap_off [N_TAPS];
   logic [TAP_W-1:0]    rd_tap;
   logic                rd_zero;
   logic [DATA_W-1:0]   ram_q;

   logic                idle, accept, direct_wr, commit_skid, ram_we, issue, cur_oob;
   logic [DATA_W-1:0]   ram_wdata;
   logic [ADDR_W-1:0]   w_addr_inc, oldest_inc, post_base, cur_off, rd_addr;
   logic [CNT_W-1:0]    post_fill;

   assign idle        = (state == ST_IDLE);
   assign s_ready     = idle && !skid_vld;
   assign busy        = !idle;
   assign accept      = start && s_ready;
   assign direct_wr   = w_en && s_ready;
   assign commit_skid = idle && skid_vld;
   assign ram_we      = direct_wr || commit_skid;
   assign ram_wdata   = commit_skid ? skid_val : w_val;
   assign full        = (fill == CNT_W'(DEPTH));
   assign w_addr_inc  = ADDR_W'(wrap_add(32'(w_addr), 32'd1, 32'(DEPTH)));
   assign oldest_inc  = ADDR_W'(wrap_add(32'(oldest_addr), 32'd1, 32'(DEPTH)));
   assign post_fill   = (direct_wr && !full) ? fill + CNT_ONE : fill;
   assign issue       = (state == ST_RD);
   assign cur_off     = snap_off[tap_cnt];
   assign cur_oob     = (CNT_W'(cur_off) >= snap_fill);

   // The snapshot sees a write accepted in the same cycle as start, so the new sample is readable.
`ifdef CIRC_BUF_NEWEST_REL_EN
   assign post_base = direct_wr ? w_addr : ADDR_W'(wrap_sub(32'(w_addr), 32'd1, 32'(DEPTH)));
   assign rd_addr   = ADDR_W'(wrap_sub(32'(snap_base), 32'(cur_off), 32'(DEPTH)));
`else
   assign post_base = (direct_wr && full) ? oldest_inc : oldest_addr;
   assign rd_addr   = ADDR_W'(wrap_add(32'(snap_base), 32'(cur_off), 32'(DEPTH)));
`endif

   // While a sweep runs, one write is parked in the skid; it drains first once idle so order is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_addr      <= '0;
         oldest_addr <= '0;
         fill        <= '0;
         skid_vld    <= 1'b0;
         skid_val    <= '0;
         ovf         <= 1'b0;
      end else begin
         if (ram_we) begin
            w_addr <= w_addr_inc;
            if (!full) fill <= fill + CNT_ONE;
            else       oldest_addr <= oldest_inc;
         end
         if (!idle) begin
            if (w_en) begin
               if (!skid_vld) begin
                  skid_vld <= 1'b1;
                  skid_val <= w_val;
               end else begin
                  ovf <= 1'b1;
               end
            end
         end else if (skid_vld) begin
            skid_vld <= w_en;
            if (w_en) skid_val <= w_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         tap_cnt   <= '0;
         snap_base <= '0;
         snap_fill <= '0;
         for (int k = 0; k < N_TAPS; k++) snap_off[k] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state     <= ST_RD;
                  tap_cnt   <= '0;
                  snap_base <= post_base;
                  snap_fill <= post_fill;
                  for (int k = 0; k < N_TAPS; k++) snap_off[k] <= tap_offset[k*ADDR_W +: ADDR_W];
               end
            end
            ST_RD: begin
               if (tap_cnt == LAST_TAP) state <= ST_DRAIN;
               else                     tap_cnt <= tap_cnt + TAP_ONE;
            end
            ST_DRAIN: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Tap results line up with the registered RAM output; rd_zero masks the unreset RAM data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         rd_tap  <= '0;
         r_oob   <= 1'b0;
         rd_zero <= 1'b1;
      end else begin
         r_valid <= issue;
         if (issue) begin
            rd_tap  <= tap_cnt;
            r_oob   <= cur_oob;
            rd_zero <= cur_oob;
         end
      end
   end

   assign r_tap  = rd_tap;
   assign r_data = rd_zero ? '0 : ram_q;
   assign done   = r_valid && (rd_tap == LAST_TAP);

   circ_buf_ram #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(w_addr),
      .wdata(ram_wdata),
      .re   (issue),
      .raddr(rd_addr),
      .rdata(ram_q)
   );

endmodule
